// File: rtl/skid_reg.sv
// skid_reg: WIDTH-bit data register with synchronous active-low reset and load enable
module skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (!resetn) q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/skid_stage.sv
// skid_stage: registered valid/ready pipeline stage with a 2-deep skid slot and saturating stall counter
module skid_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_n;
    logic accept, pop, main_ld, skid_ld;
    logic [WIDTH-1:0] main_d, skid_q;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    always_ff @(posedge clk) begin
        if (!resetn) state <= EMPTY;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_data;
        if (flush) state_n = EMPTY;
        else begin
            case (state)
                EMPTY: begin
                    main_ld = accept;
                    state_n = accept ? ONE : EMPTY;
                end
                ONE: begin
                    main_ld = accept & pop;
                    skid_ld = accept & ~pop;
                    state_n = (accept & ~pop) ? FULL : (pop & ~accept) ? EMPTY : ONE;
                end
                FULL: begin
                    main_ld = pop;
                    main_d  = skid_q;
                    state_n = pop ? ONE : FULL;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    skid_reg #(.WIDTH(WIDTH)) u_main (.clk(clk), .resetn(resetn), .load(main_ld), .d(main_d), .q(out_data));
    skid_reg #(.WIDTH(WIDTH)) u_skid (.clk(clk), .resetn(resetn), .load(skid_ld), .d(in_data), .q(skid_q));
    always_ff @(posedge clk) begin
        if (!resetn) stall_cnt <= '0;
        else if (!flush && out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_skid_stage.sv
// tb_skid_stage: directed and random checks of skid_stage against a queue-based reference model
module tb_skid_stage;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0] occupancy;
    logic [CNT_W-1:0] stall_cnt;
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last = '0;
    int m_stall = 0;
    bit m_acc = 0;

    always #5 clk = ~clk;

    skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acc, pop;
        m_acc = 0;
        if (!resetn) begin
            mq.delete();
            m_last = '0;
            m_stall = 0;
            return;
        end
        acc = in_valid && mq.size() < 2;
        pop = mq.size() > 0 && out_ready;
        if (!flush && mq.size() > 0 && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
        if (flush) begin
            mq.delete();
            return;
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
        m_acc = acc;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f, input logic rn);
        in_valid = v;
        in_data = d;
        out_ready = r;
        flush = f;
        resetn = rn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out_valid", out_valid, mq.size() > 0);
        check("in_ready", in_ready, mq.size() < 2);
        check("occupancy", occupancy, mq.size());
        check("out_data", out_data, m_last);
        check("stall_cnt", stall_cnt, m_stall);
    endtask

    initial begin
        logic v;
        logic [WIDTH-1:0] d;
        cycle(1, 'h99, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        for (int i = 1; i <= 4; i++) begin
            cycle(1, i, 1, 0, 1);
            check("stream_data", out_data, i);
            check("stream_occ", occupancy, 1);
        end
        cycle(0, 0, 1, 0, 1);
        cycle(1, 'hA, 0, 0, 1);
        cycle(1, 'hB, 0, 0, 1);
        check("bp_full_occ", occupancy, 2);
        check("bp_full_ready", in_ready, 0);
        cycle(1, 'hC, 1, 0, 1);
        check("full_pop_data", out_data, 'hB);
        check("full_pop_occ", occupancy, 1);
        cycle(1, 'hC, 1, 0, 1);
        check("after_c_data", out_data, 'hC);
        cycle(0, 0, 1, 0, 1);
        cycle(1, 'hA, 0, 0, 1);
        cycle(1, 'hB, 0, 0, 1);
        cycle(1, 'hD, 1, 1, 1);
        check("flush_occ", occupancy, 0);
        check("flush_valid", out_valid, 0);
        repeat (3) cycle(0, 0, 1, 0, 1);
        cycle(1, 'h55, 0, 0, 1);
        cycle(1, 'h66, 1, 0, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_stall", stall_cnt, 0);
        cycle(0, 0, 1, 0, 1);
        check("rst_mid_empty", out_valid, 0);
        cycle(1, 'h77, 0, 0, 1);
        repeat (20) cycle(0, 0, 0, 0, 1);
        check("stall_sat", stall_cnt, 15);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if (in_valid && !m_acc) begin
                v = in_valid;
                d = in_data;
            end else begin
                v = $urandom_range(0, 3) != 0;
                d = $urandom;
            end
            cycle(v, d, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
